// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Register address width that slot_t is built with; hazard_ctrl defaults to it.
    localparam int REG_ADR_W_DEF = 3;

    // Forward select encodings for operands in E (3 is reserved).
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic                     valid;
        logic                     wr;
        logic [REG_ADR_W_DEF-1:0] adr;
        logic                     load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/hazard_match.sv
// Compares one D-stage source operand against one in-flight slot.
// HAZARD_ZERO_REG_EN: register 0 is hardwired zero and never matches.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_ADR_W = REG_ADR_W_DEF
) (
    input  logic                 i_d_valid,
    input  logic                 i_src_used,
    input  logic [REG_ADR_W-1:0] i_src_adr,
    input  slot_t                i_slot,
    output logic                 o_match
);

    logic w_adr_eq;
    logic w_src_ok;
    logic w_unused_load;

    assign w_adr_eq      = (i_slot.adr == i_src_adr);
    assign w_unused_load = i_slot.load;

`ifdef HAZARD_ZERO_REG_EN
    // Equal addresses imply the destination is nonzero too.
    assign w_src_ok = (i_src_adr != '0);
`else
    assign w_src_ok = 1'b1;
`endif

    assign o_match = i_d_valid & i_src_used & i_slot.valid & i_slot.wr & w_adr_eq & w_src_ok;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the D -> E -> M -> W pipeline: forward selects,
// load-use stall, branch squash and register-file write port.
// HAZARD_ZERO_REG_EN: register 0 is hardwired zero (no match, no write).
// slot_t is sized by hazard_pkg::REG_ADR_W_DEF; keep REG_ADR_W equal to it.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADR_W = REG_ADR_W_DEF,
    parameter int NUM_SRC   = 2,
    parameter int PERF_W    = 16
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           d_valid,
    input  logic [NUM_SRC*REG_ADR_W-1:0]   d_src_adr,
    input  logic [NUM_SRC-1:0]             d_src_used,
    input  logic [REG_ADR_W-1:0]           d_dst_adr,
    input  logic                           d_reg_write,
    input  logic                           d_mem_to_reg,
    input  logic                           branch_taken_e,
    output logic                           stall_d,
    output logic                           flush_e,
    output logic [NUM_SRC*2-1:0]           forward_e,
    output logic                           w_reg_write,
    output logic [REG_ADR_W-1:0]           w_reg_adr,
    output logic [PERF_W-1:0]              stall_count
);

    slot_t                r_slot_e;
    slot_t                r_slot_m;
    slot_t                r_slot_w;
    logic [NUM_SRC*2-1:0] r_fwd;
    logic [PERF_W-1:0]    r_stall_cnt;

    logic [NUM_SRC-1:0]   w_match_e;
    logic [NUM_SRC-1:0]   w_match_m;
    logic [NUM_SRC*2-1:0] w_fwd_next;
    logic                 w_load_use;
    logic                 w_stall;
    logic                 w_flush;
    logic                 w_unused_w_load;

    // Each source is compared against E (next M) and M (next W); W never needs a
    // match because its write lands before the register file is read in E.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        hazard_match #(.REG_ADR_W(REG_ADR_W)) u_match_e (
            .i_d_valid  (d_valid),
            .i_src_used (d_src_used[gi]),
            .i_src_adr  (d_src_adr[gi*REG_ADR_W +: REG_ADR_W]),
            .i_slot     (r_slot_e),
            .o_match    (w_match_e[gi])
        );
        hazard_match #(.REG_ADR_W(REG_ADR_W)) u_match_m (
            .i_d_valid  (d_valid),
            .i_src_used (d_src_used[gi]),
            .i_src_adr  (d_src_adr[gi*REG_ADR_W +: REG_ADR_W]),
            .i_slot     (r_slot_m),
            .o_match    (w_match_m[gi])
        );
    end

    // Load-use stalls one cycle; a taken branch squashes and overrides the stall.
    always_comb begin
        w_load_use = (|w_match_e) & r_slot_e.load;
        w_stall    = w_load_use & ~branch_taken_e;
        w_flush    = w_load_use | branch_taken_e;
    end

    // Next forward select per channel: the younger producer (E) wins over M.
    always_comb begin
        w_fwd_next = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_fwd_next[i*2 +: 2] = FWD_RF;
            if (w_match_e[i]) begin
                w_fwd_next[i*2 +: 2] = FWD_MEM;
            end else if (w_match_m[i]) begin
                w_fwd_next[i*2 +: 2] = FWD_WB;
            end
        end
    end

    // Advance the in-flight slots; a flush drops a bubble into E.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_e <= SLOT_EMPTY;
            r_slot_m <= SLOT_EMPTY;
            r_slot_w <= SLOT_EMPTY;
        end else begin
            r_slot_w <= r_slot_m;
            r_slot_m <= r_slot_e;
            if (w_flush) begin
                r_slot_e <= SLOT_EMPTY;
            end else begin
                r_slot_e.valid <= d_valid;
                r_slot_e.wr    <= d_reg_write;
                r_slot_e.adr   <= d_dst_adr;
                r_slot_e.load  <= d_mem_to_reg;
            end
        end
    end

    // Register forward selects for the instruction entering E.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fwd <= '0;
        end else if (w_flush) begin
            r_fwd <= '0;
        end else begin
            r_fwd <= w_fwd_next;
        end
    end

    // Count load-use stall cycles, holding at the maximum.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {PERF_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + PERF_W'(1);
        end
    end

    assign w_unused_w_load = r_slot_w.load;

`ifdef HAZARD_ZERO_REG_EN
    assign w_reg_write = r_slot_w.valid & r_slot_w.wr & (r_slot_w.adr != '0);
`else
    assign w_reg_write = r_slot_w.valid & r_slot_w.wr;
`endif
    assign w_reg_adr   = r_slot_w.valid ? r_slot_w.adr : '0;
    assign stall_d     = w_stall;
    assign flush_e     = w_flush;
    assign forward_e   = r_fwd;
    assign stall_count = r_stall_cnt;

endmodule
